counter_sequencer_module: RTL and testbench

- Controller that sequences an embedded WIDTH-bit up/down counter through programmed triangle sweeps: lo -> hi -> lo, repeated for a programmed number of passes.
- Uses a start/done handshake and supports hold and abort.
- Drives count-pattern stimulus for the counter blocks in the week's lab designs, replacing hand-timed reset/mode toggling.

---
 rtl/counter_sequencer_module.sv | 139 +++++++++++++
 tb/tb_counter_sequencer_module.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer_module.sv
// counter_sequencer_module
// Sequences an embedded WIDTH-bit up/down counter through triangle sweeps
// lo -> hi -> lo, repeated for a programmed number of passes, with a
// start/done handshake, hold (freeze) and abort.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     sweep request, sampled only in IDLE
//   lo, hi    sweep bounds, latched when start is accepted
//   passes    number of full lo->hi->lo passes, latched when start is accepted
//   hold      freeze sequencing while high (UP/DOWN only)
//   abort     end the active sweep (UP/DOWN only), higher priority than hold
//   out       current count value
//   mode      1 = counting up, 0 = counting down
//   busy      high in UP/DOWN
//   done      one-cycle pulse when a sweep ends (normal, abort or rejected)
//   err       one-cycle pulse with done when the configuration is rejected
//   pass_cnt  completed passes in the current/last sweep
//
// state | meaning
// IDLE  | waiting for start, outputs hold their last values
// UP    | count rising toward hi
// DOWN  | count falling toward lo, pass completes on reaching lo
// DONE  | one-cycle end-of-sweep indication, returns to IDLE
module counter_sequencer_module #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [PASS_W-1:0] passes,
    input  logic              hold,
    input  logic              abort,
    output logic [WIDTH-1:0]  out,
    output logic              mode,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PASS_W-1:0] pass_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0]  CNT_ONE  = 1;
    localparam logic [PASS_W-1:0] PASS_ONE = 1;

    state_t              state;
    logic [WIDTH-1:0]    lo_q;
    logic [WIDTH-1:0]    hi_q;
    logic [PASS_W-1:0]   passes_q;
    logic [PASS_W-1:0]   pass_nxt;

    assign pass_nxt = pass_cnt + PASS_ONE;
    assign busy     = (state == S_UP) || (state == S_DOWN);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            out      <= '0;
            mode     <= 1'b1;
            err      <= 1'b0;
            pass_cnt <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            passes_q <= '0;
        end else begin
            // err is only ever a one-cycle pulse accompanying DONE
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if ((lo >= hi) || (passes == '0)) begin
                            state <= S_DONE;
                            err   <= 1'b1;
                        end else begin
                            lo_q     <= lo;
                            hi_q     <= hi;
                            passes_q <= passes;
                            out      <= lo;
                            mode     <= 1'b1;
                            pass_cnt <= '0;
                            state    <= S_UP;
                        end
                    end
                end
                S_UP: begin
                    if (abort) begin
                        state <= S_DONE;
                    end else if (!hold) begin
                        // hi is shown for exactly one cycle, so the turn-around
                        // jumps straight to hi-1 (lo < hi guarantees hi-1 >= lo)
                        if (out == hi_q) begin
                            out   <= hi_q - CNT_ONE;
                            mode  <= 1'b0;
                            state <= S_DOWN;
                        end else begin
                            out <= out + CNT_ONE;
                        end
                    end
                end
                S_DOWN: begin
                    if (abort) begin
                        state <= S_DONE;
                    end else if (!hold) begin
                        if (out == lo_q) begin
                            pass_cnt <= pass_nxt;
                            if (pass_nxt == passes_q) begin
                                state <= S_DONE;
                            end else begin
                                out   <= lo_q + CNT_ONE;
                                mode  <= 1'b1;
                                state <= S_UP;
                            end
                        end else begin
                            out <= out - CNT_ONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer_module.sv
module tb_counter_sequencer_module;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [2:0] passes;
    logic       hold;
    logic       abort;
    logic [3:0] out;
    logic       mode;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] pass_cnt;

    int n_checks = 0;
    int n_errors = 0;

    counter_sequencer_module #(.WIDTH(4), .PASS_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .lo       (lo),
        .hi       (hi),
        .passes   (passes),
        .hold     (hold),
        .abort    (abort),
        .out      (out),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .pass_cnt (pass_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an accepted sweep is expanded into the list of
    // (value, direction, passes-completed) it must show, one entry per cycle.
    // m_st: 0 idle, 1 sweeping, 2 end-of-sweep cycle.
    int m_st, m_out, m_mode, m_pc, m_err, m_lo, m_p, idx;
    int t_out[$];
    int t_mode[$];
    int t_pc[$];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_out = 0; m_mode = 1; m_pc = 0; m_err = 0;
    endtask

    task automatic apply_entry(input int i);
        m_out = t_out[i]; m_mode = t_mode[i]; m_pc = t_pc[i];
    endtask

    task automatic model_step(input logic s, input int l, input int h, input int p,
                              input logic hd, input logic ab);
        case (m_st)
            0: begin
                if (s) begin
                    if (l >= h || p == 0) begin
                        m_st = 2; m_err = 1;
                    end else begin
                        t_out.delete(); t_mode.delete(); t_pc.delete();
                        for (int k = 0; k < p; k++) begin
                            if (k == 0) begin
                                t_out.push_back(l); t_mode.push_back(1); t_pc.push_back(0);
                            end
                            for (int v = l + 1; v <= h; v++) begin
                                t_out.push_back(v); t_mode.push_back(1); t_pc.push_back(k);
                            end
                            for (int v = h - 1; v >= l; v--) begin
                                t_out.push_back(v); t_mode.push_back(0); t_pc.push_back(k);
                            end
                        end
                        m_lo = l; m_p = p; idx = 0; m_st = 1;
                        apply_entry(0);
                    end
                end
            end
            1: begin
                if (ab) begin
                    m_st = 2;
                end else if (!hd) begin
                    idx++;
                    if (idx >= t_out.size()) begin
                        m_st = 2; m_out = m_lo; m_mode = 0; m_pc = m_p;
                    end else begin
                        apply_entry(idx);
                    end
                end
            end
            default: begin
                m_st = 0; m_err = 0;
            end
        endcase
    endtask

    // One clock: compare at the falling edge, then drive the next inputs.
    task automatic step(input logic s, input int l, input int h, input int p,
                        input logic hd, input logic ab);
        @(negedge clk);
        check_val("out", int'(out), m_out);
        check_val("mode", int'(mode), m_mode);
        check_val("busy", int'(busy), int'(m_st == 1));
        check_val("done", int'(done), int'(m_st == 2));
        check_val("err", int'(err), m_err);
        check_val("pass_cnt", int'(pass_cnt), m_pc);
        start = s; lo = 4'(l); hi = 4'(h); passes = 3'(p); hold = hd; abort = ab;
        if (rst) model_reset();
        else model_step(s, l, h, p, hd, ab);
    endtask

    task automatic run_to_idle(input int bound);
        int n;
        n = 0;
        while (m_st != 0 && n < bound) begin
            step(0, 0, 0, 0, 0, 0);
            n++;
        end
        if (m_st != 0) check_val("idle_timeout", 0, 1);
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n, held, l, h, p;
        logic hd, ab;
        rst = 1'b0; start = 0; lo = 0; hi = 0; passes = 0; hold = 0; abort = 0;
        model_reset();
        #2 rst = 1'b1;
        #1;
        check_val("rst_out", int'(out), 0);
        check_val("rst_mode", int'(mode), 1);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_pass_cnt", int'(pass_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // single pass 2..5
        step(1, 2, 5, 1, 0, 0);
        run_to_idle(50);
        step(0, 0, 0, 0, 0, 0);

        // two passes at the top boundary
        step(1, 14, 15, 2, 0, 0);
        run_to_idle(50);

        // rejected configurations
        step(1, 5, 5, 3, 0, 0);
        run_to_idle(5);
        step(1, 1, 4, 0, 0, 0);
        run_to_idle(5);

        // hold on the up leg at 3, then abort+hold at 6 on the down leg
        step(1, 0, 7, 2, 0, 0);
        held = 0; n = 0;
        while (m_st == 1 && n < 100) begin
            hd = 0; ab = 0;
            if (m_mode == 1 && m_out == 3 && held < 3) begin
                hd = 1; held++;
            end
            if (m_mode == 0 && m_out == 6) begin
                hd = 1; ab = 1;
            end
            step(0, 0, 0, 0, hd, ab);
            n++;
        end
        check_val("hold_cycles", held, 3);
        run_to_idle(5);

        // asynchronous reset mid-sweep while out=4 on the down leg
        step(1, 0, 7, 1, 0, 0);
        n = 0;
        while (!(m_st == 1 && m_out == 4 && m_mode == 0) && n < 50) begin
            step(0, 0, 0, 0, 0, 0);
            n++;
        end
        @(posedge clk);
        #2;
        check_val("pre_rst_out", int'(out), 4);
        rst = 1'b1; start = 1; lo = 2; hi = 5; passes = 1;
        #1;
        check_val("arst_out", int'(out), 0);
        check_val("arst_mode", int'(mode), 1);
        check_val("arst_busy", int'(busy), 0);
        check_val("arst_pass_cnt", int'(pass_cnt), 0);
        model_reset();
        step(1, 2, 5, 1, 0, 0);
        step(1, 2, 5, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0; start = 0;
        step(0, 0, 0, 0, 0, 0);

        // start pulses during a busy sweep are ignored
        step(1, 1, 3, 2, 0, 0);
        step(1, 9, 12, 1, 0, 0);
        step(1, 9, 12, 1, 0, 0);
        run_to_idle(50);
        step(1, 9, 12, 1, 0, 0);
        run_to_idle(50);

        // randomized sweeps with random hold/abort and spurious starts
        for (int t = 0; t < 40; t++) begin
            l = $urandom_range(0, 15);
            if ($urandom_range(0, 4) != 0 && l < 15) h = $urandom_range(l + 1, 15);
            else h = $urandom_range(0, 15);
            p = $urandom_range(0, 3);
            step(1, l, h, p, 0, 0);
            n = 0;
            while (m_st == 1 && n < 400) begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 7), $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
                n++;
            end
            run_to_idle(10);
            if ($urandom_range(0, 1) == 1) step(0, 0, 0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
